stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
Initiator/client side of the 4-bit LIFO stack interface. It turns single-cycle CALL/RET requests carrying a multi-nibble return address into sequences of nibble PUSH/POP strobes, and reassembles popped nibbles into a full address. It sits between the core's control unit and the stack instance. It keeps a mirror occupancy count so that a frame is never partially pushed or partially popped.

Parameters:
DATA_WIDTH, 4, stack entry width.
ADDR_WIDTH, 12, return address width; must be a multiple of DATA_WIDTH. NIBBLES = ADDR_WIDTH/DATA_WIDTH (3) is a derived local constant.
STACK_DEPTH, 32, entries in the attached stack; the mirror count width is clog2(STACK_DEPTH)+1.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
CALL  in  1  push request; sampled only in IDLE
RET  in  1  pop request; sampled only in IDLE
ADDR_IN  in  ADDR_WIDTH  address to push; captured with an accepted CALL
ADDR_OUT  out  ADDR_WIDTH  reassembled popped address; holds until the next RET completes
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse when a frame push or frame pop has completed
ERR_OVF  out  1  one-cycle pulse when a CALL is rejected or aborted
ERR_UNF  out  1  one-cycle pulse when a RET is rejected or aborted
ST_PUSH  out  1  stack push strobe
ST_POP  out  1  stack pop strobe
ST_WDATA  out  DATA_WIDTH  nibble to push
ST_RDATA  in  DATA_WIDTH  stack output; valid the cycle after ST_POP
ST_FULL  in  1  stack full flag
ST_EMPTY  in  1  stack empty flag

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=IDLE, count=0, nibble index=0, address latch=0.
  - ADDR_OUT=0, BUSY=0, DONE=0, ERR_OVF=0, ERR_UNF=0, ST_PUSH=0, ST_POP=0, ST_WDATA=0.
  - Reset mid-frame abandons the frame with no DONE and no error pulse. The stack instance must be reset in the same cycle.
- States: IDLE, PUSH, POP, DRAIN, FIN.
- IDLE, CALL=1:
  - If count+NIBBLES <= STACK_DEPTH: latch ADDR_IN, go to PUSH with index=0.
  - Otherwise: ERR_OVF=1 next cycle, stay in IDLE.
- IDLE, RET=1 and CALL=0:
  - If count >= NIBBLES: go to POP with index=0.
  - Otherwise: ERR_UNF=1 next cycle, stay in IDLE.
- CALL and RET together in IDLE: CALL wins; RET is dropped silently.
- CALL/RET while BUSY: ignored, not queued.
- PUSH state:
  - ST_PUSH=1; ST_WDATA=latch nibble[index]. Least-significant nibble is pushed first.
  - Each cycle: count+1, index+1.
  - After the push with index=NIBBLES-1, go to FIN.
  - CALL timing: request at cycle 0, ST_PUSH in cycles 1..NIBBLES, DONE in cycle NIBBLES+1.
- POP state:
  - ST_POP=1; each cycle count-1, index+1.
  - Starting in the second POP cycle, each cycle captures ST_RDATA: acc = {acc[ADDR_WIDTH-DATA_WIDTH-1:0], ST_RDATA}.
  - After the pop with index=NIBBLES-1, go to DRAIN.
- DRAIN state: captures the final nibble, writes acc to ADDR_OUT, goes to FIN.
  - RET timing: request at cycle 0, ST_POP in cycles 1..NIBBLES, DONE and the new ADDR_OUT in cycle NIBBLES+2.
  - The most-significant nibble is popped first and so ends up in the MS position.
- FIN state: DONE=1 for one cycle, then IDLE. A new request can be accepted in the IDLE cycle that follows.
- Defensive aborts (these cannot occur while count stays in sync):
  - ST_FULL=1 during a PUSH cycle: suppress ST_PUSH, pulse ERR_OVF, go to IDLE, no DONE.
  - ST_EMPTY=1 during a POP cycle: same handling, with ERR_UNF.
  - count changes only for strobes actually issued.
- Invariants:
  - count never exceeds STACK_DEPTH and never wraps below 0.
  - ST_PUSH and ST_POP are never high together.
  - ADDR_OUT is unchanged by CALL frames and by rejected or aborted RETs.

Test Plan:
1. Reset, then CALL with ADDR_IN=0xABC → ST_WDATA C,B,A in cycles 1-3 with ST_PUSH=1; DONE in cycle 4; count=3; BUSY high in cycles 1-4.
2. Then RET; stack returns A,B,C → ST_POP in cycles 1-3; ADDR_OUT=0xABC with DONE in cycle 5; count=0.
3. Nested: CALL 0x123, CALL 0x456, RET, RET → ADDR_OUT 0x456 after the first RET, then 0x123 after the second; count returns to 0.
4. After reset, RET → ERR_UNF pulse in cycle 1; no ST_POP; no DONE; ADDR_OUT stays 0. Then 10 CALLs (count=30) and an 11th CALL → ERR_OVF pulse; no ST_PUSH; count stays 30.
5. CALL=RET=1 in IDLE with ADDR_IN=0x5A5 → push frame only, DONE in cycle 4. A RET pulse during cycle 2 has no effect.
6. Assert RST in the second PUSH cycle → next cycle BUSY=0, count=0, no DONE or error pulse. A following CALL 0x0F0 completes normally.

Source files
------------

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - CALL/RET frame sequencer for a nibble-wide LIFO stack
//
// Turns single-cycle CALL/RET requests into runs of nibble PUSH/POP strobes and
// reassembles popped nibbles into a full return address. A mirror occupancy
// count guarantees frames are never partially pushed or popped.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   CALL, RET         frame push / pop requests, sampled only while idle
//   ADDR_IN           address pushed by an accepted CALL
//   ADDR_OUT          last address reassembled by a completed RET
//   BUSY, DONE        sequencer active / one-cycle frame-complete pulse
//   ERR_OVF, ERR_UNF  one-cycle pulses for rejected or aborted CALL / RET
//   ST_PUSH, ST_POP   stack strobes
//   ST_WDATA          nibble to push
//   ST_RDATA          stack output, valid the cycle after ST_POP
//   ST_FULL, ST_EMPTY stack status flags
module stack_sequencer #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 12,
  parameter int STACK_DEPTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CALL,
  input  logic                  RET,
  input  logic [ADDR_WIDTH-1:0] ADDR_IN,
  output logic [ADDR_WIDTH-1:0] ADDR_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR_OVF,
  output logic                  ERR_UNF,
  output logic                  ST_PUSH,
  output logic                  ST_POP,
  output logic [DATA_WIDTH-1:0] ST_WDATA,
  input  logic [DATA_WIDTH-1:0] ST_RDATA,
  input  logic                  ST_FULL,
  input  logic                  ST_EMPTY
);

  localparam int NIBBLES = ADDR_WIDTH / DATA_WIDTH;
  localparam int CW      = $clog2(STACK_DEPTH) + 1;
  localparam int CWX     = CW + 1;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IW-1:0]  IDX_LAST  = IW'(NIBBLES - 1);
  localparam logic [CW-1:0]  CNT_FRAME = CW'(NIBBLES);
  localparam logic [CWX-1:0] CNT_LIMIT = CWX'(STACK_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PUSH  = 3'd1;
  localparam logic [2:0] S_POP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]                            state_q, state_d;
  logic [CW-1:0]                         count_q, count_d;
  logic [IW-1:0]                         idx_q, idx_d;
  logic [NIBBLES-1:0][DATA_WIDTH-1:0]    addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]                 acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]                 addr_out_q, addr_out_d;
  logic                                  err_ovf_q, err_ovf_d;
  logic                                  err_unf_q, err_unf_d;

  // Widened by one bit so the room check cannot wrap near a full stack.
  logic [CWX-1:0] count_after_call;
  assign count_after_call = {1'b0, count_q} + CWX'(NIBBLES);

  // Strobes are suppressed by the stack flags so the mirror count only
  // follows strobes that were really issued.
  assign ST_PUSH  = (state_q == S_PUSH) && !ST_FULL;
  assign ST_POP   = (state_q == S_POP) && !ST_EMPTY;
  assign ST_WDATA = ST_PUSH ? addr_q[idx_q] : '0;
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FIN);
  assign ERR_OVF  = err_ovf_q;
  assign ERR_UNF  = err_unf_q;
  assign ADDR_OUT = addr_out_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    addr_out_d = addr_out_q;
    err_ovf_d  = 1'b0;
    err_unf_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // CALL has priority; a simultaneous RET is dropped.
        if (CALL) begin
          if (count_after_call <= CNT_LIMIT) begin
            addr_d  = ADDR_IN;
            idx_d   = '0;
            state_d = S_PUSH;
          end else begin
            err_ovf_d = 1'b1;
          end
        end else if (RET) begin
          if (count_q >= CNT_FRAME) begin
            idx_d   = '0;
            state_d = S_POP;
          end else begin
            err_unf_d = 1'b1;
          end
        end
      end

      S_PUSH: begin
        if (ST_FULL) begin
          err_ovf_d = 1'b1;
          idx_d     = '0;
          state_d   = S_IDLE;
        end else begin
          count_d = count_q + 1'b1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_FIN;
          end
        end
      end

      S_POP: begin
        if (ST_EMPTY) begin
          err_unf_d = 1'b1;
          idx_d     = '0;
          state_d   = S_IDLE;
        end else begin
          count_d = count_q - 1'b1;
          idx_d   = idx_q + 1'b1;
          // Read data lags the pop by one cycle, so the first POP cycle has
          // nothing to capture yet.
          if (idx_q != '0) begin
            acc_d = {acc_q[ADDR_WIDTH-DATA_WIDTH-1:0], ST_RDATA};
          end
          if (idx_q == IDX_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        acc_d      = {acc_q[ADDR_WIDTH-DATA_WIDTH-1:0], ST_RDATA};
        addr_out_d = {acc_q[ADDR_WIDTH-DATA_WIDTH-1:0], ST_RDATA};
        idx_d      = '0;
        state_d    = S_FIN;
      end

      S_FIN: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      acc_q      <= '0;
      addr_out_q <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      addr_out_q <= addr_out_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - directed self-checking bench for stack_sequencer
module tb_stack_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CALL = 1'b0;
  logic        RET = 1'b0;
  logic [11:0] ADDR_IN = '0;
  logic [11:0] ADDR_OUT;
  logic        BUSY, DONE, ERR_OVF, ERR_UNF, ST_PUSH, ST_POP;
  logic [3:0]  ST_WDATA;
  logic [3:0]  ST_RDATA;
  logic        ST_FULL, ST_EMPTY;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural 32x4 stack attached to the sequencer.
  logic [3:0] mem [0:31];
  int         sp = 0;
  logic [3:0] rdata_q = '0;
  logic       force_full = 1'b0;
  logic       force_empty = 1'b0;

  assign ST_FULL  = (sp == 32) || force_full;
  assign ST_EMPTY = (sp == 0) || force_empty;
  assign ST_RDATA = rdata_q;

  always @(posedge CLK) begin
    if (RST) begin
      sp      <= 0;
      rdata_q <= '0;
    end else if (ST_PUSH) begin
      mem[sp] <= ST_WDATA;
      sp      <= sp + 1;
    end else if (ST_POP) begin
      rdata_q <= mem[sp-1];
      sp      <= sp - 1;
    end
  end

  always #5 CLK = ~CLK;

  stack_sequencer #(.DATA_WIDTH(4), .ADDR_WIDTH(12), .STACK_DEPTH(32)) dut (
    .CLK(CLK), .RST(RST), .CALL(CALL), .RET(RET), .ADDR_IN(ADDR_IN),
    .ADDR_OUT(ADDR_OUT), .BUSY(BUSY), .DONE(DONE), .ERR_OVF(ERR_OVF),
    .ERR_UNF(ERR_UNF), .ST_PUSH(ST_PUSH), .ST_POP(ST_POP), .ST_WDATA(ST_WDATA),
    .ST_RDATA(ST_RDATA), .ST_FULL(ST_FULL), .ST_EMPTY(ST_EMPTY)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic call_frame(input logic [11:0] addr);
    CALL = 1'b1;
    ADDR_IN = addr;
    tick();
    CALL = 1'b0;
    for (int i = 0; i < 10 && !DONE; i++) tick();
    tests_run++;
    if (DONE !== 1'b1) begin
      tests_failed++;
      $display("FAIL call_frame_timeout addr=%h done=%b want 1", addr, DONE);
    end
    tick();
  endtask

  task automatic ret_frame();
    RET = 1'b1;
    tick();
    RET = 1'b0;
    for (int i = 0; i < 10 && !DONE; i++) tick();
    tests_run++;
    if (DONE !== 1'b1) begin
      tests_failed++;
      $display("FAIL ret_frame_timeout done=%b want 1", DONE);
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({BUSY, DONE, ERR_OVF, ERR_UNF, ST_PUSH, ST_POP} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b want 000000",
               {BUSY, DONE, ERR_OVF, ERR_UNF, ST_PUSH, ST_POP});
    end
    tests_run++;
    if (ADDR_OUT !== 12'h000 || ST_WDATA !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_data addr_out=%h wdata=%h want 000/0", ADDR_OUT, ST_WDATA);
    end
    tests_run++;
    if (dut.count_q !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_count got=%0d want 0", dut.count_q);
    end
  endtask

  task automatic test_call_basic();
    logic [11:0] a;
    a = 12'hABC;
    CALL = 1'b1;
    ADDR_IN = a;
    tick();
    CALL = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (ST_PUSH !== 1'b1 || ST_WDATA !== a[4*k +: 4] || BUSY !== 1'b1 || DONE !== 1'b0) begin
        tests_failed++;
        $display("FAIL call_push_c%0d push=%b wdata=%h busy=%b done=%b want 1/%h/1/0",
                 k + 1, ST_PUSH, ST_WDATA, BUSY, DONE, a[4*k +: 4]);
      end
      tick();
    end
    tests_run++;
    if (DONE !== 1'b1 || BUSY !== 1'b1 || ST_PUSH !== 1'b0) begin
      tests_failed++;
      $display("FAIL call_done_c4 done=%b busy=%b push=%b want 1/1/0", DONE, BUSY, ST_PUSH);
    end
    tick();
    tests_run++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || dut.count_q !== 6'd3) begin
      tests_failed++;
      $display("FAIL call_idle_c5 done=%b busy=%b count=%0d want 0/0/3", DONE, BUSY, dut.count_q);
    end
  endtask

  task automatic test_ret_basic();
    RET = 1'b1;
    tick();
    RET = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tests_run++;
      if (ST_POP !== 1'b1 || ST_PUSH !== 1'b0 || BUSY !== 1'b1 || DONE !== 1'b0) begin
        tests_failed++;
        $display("FAIL ret_pop_c%0d pop=%b push=%b busy=%b done=%b want 1/0/1/0",
                 k, ST_POP, ST_PUSH, BUSY, DONE);
      end
      tick();
    end
    tests_run++;
    if (ST_POP !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b1 || ADDR_OUT !== 12'h000) begin
      tests_failed++;
      $display("FAIL ret_drain_c4 pop=%b done=%b busy=%b addr_out=%h want 0/0/1/000",
               ST_POP, DONE, BUSY, ADDR_OUT);
    end
    tick();
    tests_run++;
    if (DONE !== 1'b1 || ADDR_OUT !== 12'hABC) begin
      tests_failed++;
      $display("FAIL ret_done_c5 done=%b addr_out=%h want 1/abc", DONE, ADDR_OUT);
    end
    tick();
    tests_run++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || dut.count_q !== 6'd0) begin
      tests_failed++;
      $display("FAIL ret_idle_c6 done=%b busy=%b count=%0d want 0/0/0", DONE, BUSY, dut.count_q);
    end
  endtask

  task automatic test_nested();
    call_frame(12'h123);
    call_frame(12'h456);
    ret_frame();
    tests_run++;
    if (ADDR_OUT !== 12'h456) begin
      tests_failed++;
      $display("FAIL nested_ret1 addr_out=%h want 456", ADDR_OUT);
    end
    ret_frame();
    tests_run++;
    if (ADDR_OUT !== 12'h123 || dut.count_q !== 6'd0) begin
      tests_failed++;
      $display("FAIL nested_ret2 addr_out=%h count=%0d want 123/0", ADDR_OUT, dut.count_q);
    end
  endtask

  task automatic test_errors();
    do_reset();
    RET = 1'b1;
    tick();
    RET = 1'b0;
    tests_run++;
    if (ERR_UNF !== 1'b1 || ST_POP !== 1'b0 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL unf_pulse err_unf=%b pop=%b busy=%b want 1/0/0", ERR_UNF, ST_POP, BUSY);
    end
    tick();
    tests_run++;
    if (ERR_UNF !== 1'b0 || DONE !== 1'b0 || ADDR_OUT !== 12'h000) begin
      tests_failed++;
      $display("FAIL unf_after err_unf=%b done=%b addr_out=%h want 0/0/000", ERR_UNF, DONE, ADDR_OUT);
    end
    for (int i = 0; i < 10; i++) call_frame(12'h100 + 12'(i));
    tests_run++;
    if (dut.count_q !== 6'd30 || sp != 30) begin
      tests_failed++;
      $display("FAIL fill_count count=%0d sp=%0d want 30/30", dut.count_q, sp);
    end
    CALL = 1'b1;
    ADDR_IN = 12'hFFF;
    tick();
    CALL = 1'b0;
    tests_run++;
    if (ERR_OVF !== 1'b1 || ST_PUSH !== 1'b0 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_pulse err_ovf=%b push=%b busy=%b want 1/0/0", ERR_OVF, ST_PUSH, BUSY);
    end
    tick();
    tests_run++;
    if (ERR_OVF !== 1'b0 || dut.count_q !== 6'd30 || sp != 30) begin
      tests_failed++;
      $display("FAIL ovf_after err_ovf=%b count=%0d sp=%0d want 0/30/30", ERR_OVF, dut.count_q, sp);
    end
  endtask

  task automatic test_call_ret_together();
    logic [11:0] a;
    a = 12'h5A5;
    do_reset();
    CALL = 1'b1;
    RET = 1'b1;
    ADDR_IN = a;
    tick();
    CALL = 1'b0;
    RET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (ST_PUSH !== 1'b1 || ST_POP !== 1'b0 || ST_WDATA !== a[4*k +: 4]) begin
        tests_failed++;
        $display("FAIL both_push_c%0d push=%b pop=%b wdata=%h want 1/0/%h",
                 k + 1, ST_PUSH, ST_POP, ST_WDATA, a[4*k +: 4]);
      end
      RET = (k == 1);
      tick();
      RET = 1'b0;
    end
    tests_run++;
    if (DONE !== 1'b1 || ST_POP !== 1'b0) begin
      tests_failed++;
      $display("FAIL both_done_c4 done=%b pop=%b want 1/0", DONE, ST_POP);
    end
    tick();
    tests_run++;
    if (BUSY !== 1'b0 || ST_POP !== 1'b0 || dut.count_q !== 6'd3 || ADDR_OUT !== 12'h000) begin
      tests_failed++;
      $display("FAIL both_idle_c5 busy=%b pop=%b count=%0d addr_out=%h want 0/0/3/000",
               BUSY, ST_POP, dut.count_q, ADDR_OUT);
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] a;
    CALL = 1'b1;
    ADDR_IN = 12'h777;
    tick();
    CALL = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tests_run++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || ERR_OVF !== 1'b0 || ERR_UNF !== 1'b0 || dut.count_q !== 6'd0) begin
      tests_failed++;
      $display("FAIL midrst_c3 busy=%b done=%b ovf=%b unf=%b count=%0d want 0/0/0/0/0",
               BUSY, DONE, ERR_OVF, ERR_UNF, dut.count_q);
    end
    tick();
    tests_run++;
    if (DONE !== 1'b0 || ERR_OVF !== 1'b0 || ERR_UNF !== 1'b0 || ST_PUSH !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_c4 done=%b ovf=%b unf=%b push=%b want 0/0/0/0", DONE, ERR_OVF, ERR_UNF, ST_PUSH);
    end
    a = 12'h0F0;
    CALL = 1'b1;
    ADDR_IN = a;
    tick();
    CALL = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (ST_PUSH !== 1'b1 || ST_WDATA !== a[4*k +: 4]) begin
        tests_failed++;
        $display("FAIL midrst_push_c%0d push=%b wdata=%h want 1/%h", k + 1, ST_PUSH, ST_WDATA, a[4*k +: 4]);
      end
      tick();
    end
    tests_run++;
    if (DONE !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_done done=%b want 1", DONE);
    end
    tick();
    ret_frame();
    tests_run++;
    if (ADDR_OUT !== 12'h0F0 || dut.count_q !== 6'd0) begin
      tests_failed++;
      $display("FAIL midrst_ret addr_out=%h count=%0d want 0f0/0", ADDR_OUT, dut.count_q);
    end
  endtask

  task automatic test_flag_aborts();
    do_reset();
    force_full = 1'b1;
    CALL = 1'b1;
    ADDR_IN = 12'h321;
    tick();
    CALL = 1'b0;
    tests_run++;
    if (ST_PUSH !== 1'b0 || BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_abort_c1 push=%b busy=%b want 0/1", ST_PUSH, BUSY);
    end
    tick();
    force_full = 1'b0;
    tests_run++;
    if (ERR_OVF !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || dut.count_q !== 6'd0) begin
      tests_failed++;
      $display("FAIL full_abort_c2 ovf=%b busy=%b done=%b count=%0d want 1/0/0/0",
               ERR_OVF, BUSY, DONE, dut.count_q);
    end
    call_frame(12'h321);
    force_empty = 1'b1;
    RET = 1'b1;
    tick();
    RET = 1'b0;
    tests_run++;
    if (ST_POP !== 1'b0 || BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_abort_c1 pop=%b busy=%b want 0/1", ST_POP, BUSY);
    end
    tick();
    force_empty = 1'b0;
    tests_run++;
    if (ERR_UNF !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || dut.count_q !== 6'd3 || ADDR_OUT !== 12'h000) begin
      tests_failed++;
      $display("FAIL empty_abort_c2 unf=%b busy=%b done=%b count=%0d addr_out=%h want 1/0/0/3/000",
               ERR_UNF, BUSY, DONE, dut.count_q, ADDR_OUT);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_call_basic();
    test_ret_basic();
    test_nested();
    test_errors();
    test_call_ret_together();
    test_reset_midframe();
    test_flag_aborts();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
